multi_channel_synchronizer: RTL and testbench

Parametrised per-bit synchronizer for asynchronous flags and slow levels entering a single clock domain. Each channel is a configurable-depth flip-flop chain followed by an optional glitch filter, which only accepts a new level after it has been stable for a programmable number of cycles. Each channel also produces single-cycle rising and falling edge pulses. The block sits at every asynchronous input boundary: external pins, status lines from other clock domains, and slow control bits.

---
 rtl/multi_channel_synchronizer.sv | 81 ++++++++
 tb/tb_multi_channel_synchronizer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multi_channel_synchronizer.sv
// rtl/multi_channel_synchronizer.sv - per-bit synchronizer chain with optional glitch filter and edge pulses
module multi_channel_synchronizer #(
  parameter int                 WIDTH       = 1,
  parameter int                 STAGES      = 3,
  parameter int                 FILTER_LEN  = 0,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  // A single-flop "chain" gives no metastability protection at all.
  if (STAGES < 2) begin : g_bad_stages
    $error("multi_channel_synchronizer: STAGES must be at least 2");
  end

  // Stage 0 is the only flop allowed to go metastable; nothing but stage 1 reads it.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] r_out_prev;

  // Plain shift chain, no logic between stages so the tools keep the flops together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync <= {STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], IN};
    end
  end

  assign w_last = r_sync[STAGES-1];

  if (FILTER_LEN == 0) begin : g_bypass
    assign OUT = w_last;
  end else begin : g_filter
    localparam int             CW      = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt [WIDTH];

    // Accept a new level only after it disagrees with OUT for FILTER_LEN consecutive cycles.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_out <= RESET_VALUE;
        for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_last[i] == r_out[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == CNT_MAX) begin
            r_out[i] <= w_last[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end

    assign OUT = r_out;
  end

  // History of OUT for edge detection; loaded with the reset value so reset itself makes no edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_prev <= RESET_VALUE;
    end else begin
      r_out_prev <= OUT;
    end
  end

  // Pulses are suppressed while reset is held, even if OUT still shows a pre-reset level.
  assign RISE = OUT  & ~r_out_prev & {WIDTH{~RESET}};
  assign FALL = ~OUT &  r_out_prev & {WIDTH{~RESET}};

endmodule

// File: tb/tb_multi_channel_synchronizer.sv
// tb/tb_multi_channel_synchronizer.sv - scoreboard bench for multi_channel_synchronizer
module tb_multi_channel_synchronizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // c: 8-bit bypass, b: filter 4, d: filter 8, e: reset value FF, f: 2 stages filter 1
  logic       rst_c = 1'b1, rst_b = 1'b1, rst_d = 1'b1, rst_e = 1'b1, rst_f = 1'b1;
  logic [7:0] in_c = 8'h00, in_e = 8'hFF;
  logic       in_b = 1'b0, in_d = 1'b0, in_f = 1'b0;
  logic [7:0] c_out, c_rise, c_fall, e_out, e_rise, e_fall;
  logic       b_out, b_rise, b_fall, d_out, d_rise, d_fall, f_out, f_rise, f_fall;

  multi_channel_synchronizer #(.WIDTH(8), .STAGES(3), .FILTER_LEN(0)) u_c (
    .CLK(clk), .RESET(rst_c), .IN(in_c), .OUT(c_out), .RISE(c_rise), .FALL(c_fall));
  multi_channel_synchronizer #(.WIDTH(1), .STAGES(3), .FILTER_LEN(4)) u_b (
    .CLK(clk), .RESET(rst_b), .IN(in_b), .OUT(b_out), .RISE(b_rise), .FALL(b_fall));
  multi_channel_synchronizer #(.WIDTH(1), .STAGES(3), .FILTER_LEN(8)) u_d (
    .CLK(clk), .RESET(rst_d), .IN(in_d), .OUT(d_out), .RISE(d_rise), .FALL(d_fall));
  multi_channel_synchronizer #(.WIDTH(8), .STAGES(3), .FILTER_LEN(0), .RESET_VALUE(8'hFF)) u_e (
    .CLK(clk), .RESET(rst_e), .IN(in_e), .OUT(e_out), .RISE(e_rise), .FALL(e_fall));
  multi_channel_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_LEN(1)) u_f (
    .CLK(clk), .RESET(rst_f), .IN(in_f), .OUT(f_out), .RISE(f_rise), .FALL(f_fall));

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] row;
    logic [7:0] o;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  exp_t       q[$];
  logic [2:0] sel = 3'd0;
  logic [7:0] row = 8'd0;
  int         checks = 0;
  int         errors = 0;

  // Apply one cycle of stimulus to the selected DUT and queue what it must show this cycle.
  task automatic drive(input logic rst, input logic [7:0] din,
                       input logic [7:0] eo, input logic [7:0] er, input logic [7:0] ef);
    @(posedge clk);
    #1;
    case (sel)
      3'd0: begin rst_c = rst; in_c = din;    end
      3'd1: begin rst_b = rst; in_b = din[0]; end
      3'd2: begin rst_d = rst; in_d = din[0]; end
      3'd3: begin rst_e = rst; in_e = din;    end
      default: begin rst_f = rst; in_f = din[0]; end
    endcase
    q.push_back('{sel, row, eo, er, ef});
    row = row + 8'd1;
  endtask

  task automatic start(input logic [2:0] s);
    sel = s;
    row = 8'd0;
  endtask

  // Monitor: every cycle with a queued expectation, compare the selected DUT mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [7:0] ao, ar, af;
      string      nm;
      e = q.pop_front();
      case (e.sel)
        3'd0: begin ao = c_out; ar = c_rise; af = c_fall; nm = "bypass8"; end
        3'd1: begin ao = {7'd0, b_out}; ar = {7'd0, b_rise}; af = {7'd0, b_fall}; nm = "filter4"; end
        3'd2: begin ao = {7'd0, d_out}; ar = {7'd0, d_rise}; af = {7'd0, d_fall}; nm = "filter8_reset"; end
        3'd3: begin ao = e_out; ar = e_rise; af = e_fall; nm = "resetval_ff"; end
        default: begin ao = {7'd0, f_out}; ar = {7'd0, f_rise}; af = {7'd0, f_fall}; nm = "stages2_filter1"; end
      endcase
      checks++;
      if ({ao, ar, af} !== {e.o, e.r, e.f}) begin
        errors++;
        $display("FAIL %s row %0d: out=%h rise=%h fall=%h, expected out=%h rise=%h fall=%h",
                 nm, e.row, ao, ar, af, e.o, e.r, e.f);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);

    // Bypass, 8 channels: single rise on bit 0, then A5 -> 5A, then a toggling bit.
    start(3'd0);
    drive(1, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h01, 8'h00);
    repeat (3) drive(0, 8'hA5, 8'h01, 8'h00, 8'h00);
    drive(0, 8'hA5, 8'hA5, 8'hA4, 8'h00);
    repeat (3) drive(0, 8'h5A, 8'hA5, 8'h00, 8'h00);
    drive(0, 8'h5A, 8'h5A, 8'h5A, 8'hA5);
    drive(0, 8'h5A, 8'h5A, 8'h00, 8'h00);
    drive(0, 8'h5B, 8'h5A, 8'h00, 8'h00);
    drive(0, 8'h5A, 8'h5A, 8'h00, 8'h00);
    drive(0, 8'h5B, 8'h5A, 8'h00, 8'h00);
    drive(0, 8'h5A, 8'h5B, 8'h01, 8'h00);
    drive(0, 8'h5A, 8'h5A, 8'h00, 8'h01);
    drive(0, 8'h5A, 8'h5B, 8'h01, 8'h00);
    drive(0, 8'h5A, 8'h5A, 8'h00, 8'h01);
    drive(0, 8'h5A, 8'h5A, 8'h00, 8'h00);

    // Filter 4: 3-cycle pulse rejected, 1-cycle dropout restarts the count, then reset and hold high.
    start(3'd1);
    drive(1, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    repeat (4) drive(0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (7) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h01, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h00, 8'h00);
    drive(1, 8'h01, 8'h01, 8'h00, 8'h00);
    repeat (7) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h01, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h00, 8'h00);

    // Filter 8: reset lands mid-count, then a full STAGES+8 edges are needed again.
    start(3'd2);
    drive(1, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (8) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(1, 8'h01, 8'h00, 8'h00, 8'h00);
    repeat (11) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h01, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h00, 8'h00);

    // Reset value FF with IN=FF: no pulses; reset gates a pending FALL; later bit-0 drop.
    start(3'd3);
    drive(1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    repeat (5) drive(0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    repeat (3) drive(0, 8'hFE, 8'hFF, 8'h00, 8'h00);
    drive(1, 8'hFE, 8'hFE, 8'h00, 8'h00);
    repeat (3) drive(0, 8'hFE, 8'hFF, 8'h00, 8'h00);
    drive(0, 8'hFE, 8'hFE, 8'h00, 8'h01);
    drive(0, 8'hFE, 8'hFE, 8'h00, 8'h00);

    // Two stages, filter 1: rise after edge 3, fall likewise, and an unsampled glitch is ignored.
    start(3'd4);
    drive(1, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(0, 8'h01, 8'h00, 8'h00, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h01, 8'h00);
    drive(0, 8'h01, 8'h01, 8'h00, 8'h00);
    repeat (3) drive(0, 8'h00, 8'h01, 8'h00, 8'h00);
    drive(0, 8'h00, 8'h00, 8'h00, 8'h01);
    drive(0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 in_f = 1'b1;
    #1 in_f = 1'b0;
    repeat (4) drive(0, 8'h00, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
